// File: rtl/bfm_apb_arbiter.sv
// -----------------------------------------------------------------------------
// bfm_apb_arbiter
//
// Round-robin arbiter that shares one APB3 master port among NREQ APB3
// requesters (BFM masters, bridge PM sides). Each granted request is latched,
// re-timed onto the master port, and its PRDATA/PSLVERR are returned to the
// winner together with a one-cycle PREADY pulse. A slave that never raises
// PREADY is abandoned after TIMEOUT ACCESS cycles and the requester receives
// an error response. Every output comes straight from a register, and no
// output delay is modelled.
//
// Parameters
//   NREQ     number of requesters, 1..4
//   TIMEOUT  max ACCESS cycles before abort; 0 disables the timeout
//
// Ports
//   PCLK, PRESETN     clock (rising edge) and async active-low reset
//   REQ_PSEL          per-requester PSEL (the only arbitration input)
//   REQ_PENABLE       per-requester PENABLE (ignored)
//   REQ_PWRITE        per-requester PWRITE
//   REQ_PADDR         packed addresses, requester i at [32i+31:32i]
//   REQ_PWDATA        packed write data, same packing as REQ_PADDR
//   REQ_PRDATA        shared read data, valid with REQ_PREADY, held afterwards
//   REQ_PREADY        one-hot completion pulse to the granted requester
//   REQ_PSLVERR       shared error flag, valid with REQ_PREADY
//   PSEL_M..PWDATA_M  master-side APB request outputs
//   PRDATA_M, PREADY_M, PSLVERR_M  master-side slave response inputs
//   GNT_ID            index of the current or most recent grant
//   BUSY              high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module bfm_apb_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESETN,
    input  logic [NREQ-1:0]      REQ_PSEL,
    input  logic [NREQ-1:0]      REQ_PENABLE,
    input  logic [NREQ-1:0]      REQ_PWRITE,
    input  logic [32*NREQ-1:0]   REQ_PADDR,
    input  logic [32*NREQ-1:0]   REQ_PWDATA,
    output logic [31:0]          REQ_PRDATA,
    output logic [NREQ-1:0]      REQ_PREADY,
    output logic                 REQ_PSLVERR,
    output logic                 PSEL_M,
    output logic                 PENABLE_M,
    output logic                 PWRITE_M,
    output logic [31:0]          PADDR_M,
    output logic [31:0]          PWDATA_M,
    input  logic [31:0]          PRDATA_M,
    input  logic                 PREADY_M,
    input  logic                 PSLVERR_M,
    output logic [1:0]           GNT_ID,
    output logic                 BUSY
);

    // Counter only ever has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [31:0]       paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [31:0]       prdata_q, prdata_d;
    logic [NREQ-1:0]   pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              busy_q, busy_d;

    // Requester inputs widened to four slots so a 2-bit grant index selects
    // them directly for any NREQ; unused slots read as zero.
    logic [3:0]        psel_pad;
    logic [3:0]        pwrite_pad;
    logic [3:0][31:0]  paddr_pad;
    logic [3:0][31:0]  pwdata_pad;

    assign psel_pad   = 4'(REQ_PSEL);
    assign pwrite_pad = 4'(REQ_PWRITE);
    assign paddr_pad  = 128'(REQ_PADDR);
    assign pwdata_pad = 128'(REQ_PWDATA);

    // Requester PENABLE plays no part in arbitration or the transfer.
    logic unused_penable;
    assign unused_penable = ^REQ_PENABLE;

    // ------------------------------------------------------------------
    // Round-robin pick: first requesting index after LAST, wrapping at NREQ.
    // ------------------------------------------------------------------
    logic       win_valid;
    logic [1:0] win_id;
    logic [1:0] cand;

    always_comb begin
        win_valid = 1'b0;
        win_id    = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = 2'((int'(last_q) + i) % NREQ);
            if (!win_valid && psel_pad[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    // NOTE: every variable written here is given its hold value first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;

        unique case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    gnt_d     = win_id;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = pwrite_pad[win_id];
                    paddr_d   = paddr_pad[win_id];
                    pwdata_d  = pwdata_pad[win_id];
                    state_d   = S_SETUP;
                end
            end

            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end

            S_ACCESS: begin
                if (PREADY_M) begin
                    prdata_d  = pwrite_q ? 32'd0 : PRDATA_M;
                    pslverr_d = PSLVERR_M;
                    pready_d  = NREQ'(1) << gnt_q;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    pwrite_d  = 1'b0;
                    paddr_d   = 32'd0;
                    pwdata_d  = 32'd0;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Hung slave: drop the master side and report an error.
                    if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        prdata_d  = 32'd0;
                        pslverr_d = 1'b1;
                        pready_d  = NREQ'(1) << gnt_q;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        pwrite_d  = 1'b0;
                        paddr_d   = 32'd0;
                        pwdata_d  = 32'd0;
                        state_d   = S_RESP;
                    end
                end
            end

            S_RESP: begin
                // REQ_PRDATA deliberately keeps its value until the next RESP.
                pready_d  = '0;
                pslverr_d = 1'b0;
                last_d    = gnt_q;
                state_d   = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments make every register sample its _d value
    // from before the edge, independent of statement order.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= S_IDLE;
            last_q    <= 2'(NREQ - 1);
            gnt_q     <= 2'd0;
            cnt_q     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= 32'd0;
            pwdata_q  <= 32'd0;
            prdata_q  <= 32'd0;
            pready_q  <= '0;
            pslverr_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            busy_q    <= busy_d;
        end
    end

    assign PSEL_M      = psel_q;
    assign PENABLE_M   = penable_q;
    assign PWRITE_M    = pwrite_q;
    assign PADDR_M     = paddr_q;
    assign PWDATA_M    = pwdata_q;
    assign REQ_PRDATA  = prdata_q;
    assign REQ_PREADY  = pready_q;
    assign REQ_PSLVERR = pslverr_q;
    assign GNT_ID      = gnt_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_bfm_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bfm_apb_arbiter
//
// Directed bench for bfm_apb_arbiter with NREQ=2, TIMEOUT=8. Inputs change
// 1 time unit after a rising edge, and outputs are sampled at that same point,
// well away from the next edge. Expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_bfm_apb_arbiter;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 8;

    logic              PCLK;
    logic              PRESETN;
    logic [NREQ-1:0]   REQ_PSEL;
    logic [NREQ-1:0]   REQ_PENABLE;
    logic [NREQ-1:0]   REQ_PWRITE;
    logic [63:0]       REQ_PADDR;
    logic [63:0]       REQ_PWDATA;
    logic [31:0]       REQ_PRDATA;
    logic [NREQ-1:0]   REQ_PREADY;
    logic              REQ_PSLVERR;
    logic              PSEL_M;
    logic              PENABLE_M;
    logic              PWRITE_M;
    logic [31:0]       PADDR_M;
    logic [31:0]       PWDATA_M;
    logic [31:0]       PRDATA_M;
    logic              PREADY_M;
    logic              PSLVERR_M;
    logic [1:0]        GNT_ID;
    logic              BUSY;

    int n_checks = 0;
    int n_errors = 0;

    bfm_apb_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .REQ_PSEL    (REQ_PSEL),
        .REQ_PENABLE (REQ_PENABLE),
        .REQ_PWRITE  (REQ_PWRITE),
        .REQ_PADDR   (REQ_PADDR),
        .REQ_PWDATA  (REQ_PWDATA),
        .REQ_PRDATA  (REQ_PRDATA),
        .REQ_PREADY  (REQ_PREADY),
        .REQ_PSLVERR (REQ_PSLVERR),
        .PSEL_M      (PSEL_M),
        .PENABLE_M   (PENABLE_M),
        .PWRITE_M    (PWRITE_M),
        .PADDR_M     (PADDR_M),
        .PWDATA_M    (PWDATA_M),
        .PRDATA_M    (PRDATA_M),
        .PREADY_M    (PREADY_M),
        .PSLVERR_M   (PSLVERR_M),
        .GNT_ID      (GNT_ID),
        .BUSY        (BUSY)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(input logic idx, input logic sel, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
        REQ_PSEL[idx]    = sel;
        REQ_PENABLE[idx] = sel;
        REQ_PWRITE[idx]  = wr;
        if (idx) begin
            REQ_PADDR[63:32]  = addr;
            REQ_PWDATA[63:32] = wdata;
        end else begin
            REQ_PADDR[31:0]  = addr;
            REQ_PWDATA[31:0] = wdata;
        end
    endtask

    task automatic drop_req(input logic idx);
        set_req(idx, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic apply_reset();
        PRESETN     = 1'b0;
        REQ_PSEL    = '0;
        REQ_PENABLE = '0;
        REQ_PWRITE  = '0;
        REQ_PADDR   = '0;
        REQ_PWDATA  = '0;
        tick();
        tick();
        PRESETN = 1'b1;
    endtask

    // One zero-wait transfer starting from IDLE with PREADY_M already high:
    // grant edge, SETUP edge, ACCESS edge (completion), RESP edge.
    task automatic xfer(input string tag, input logic gnt,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                        input logic [31:0] rdata, input logic err);
        logic [1:0] rdy;
        rdy = gnt ? 2'b10 : 2'b01;
        tick();
        check({tag, ".grant.psel"},    32'(PSEL_M),     32'd1);
        check({tag, ".grant.penable"}, 32'(PENABLE_M),  32'd0);
        check({tag, ".grant.gnt_id"},  32'(GNT_ID),     32'({1'b0, gnt}));
        check({tag, ".grant.paddr"},   PADDR_M,         addr);
        check({tag, ".grant.pwdata"},  PWDATA_M,        wdata);
        check({tag, ".grant.pwrite"},  32'(PWRITE_M),   32'(wr));
        check({tag, ".grant.busy"},    32'(BUSY),       32'd1);
        check({tag, ".grant.pready"},  32'(REQ_PREADY), 32'd0);
        tick();
        check({tag, ".setup.psel"},    32'(PSEL_M),     32'd1);
        check({tag, ".setup.penable"}, 32'(PENABLE_M),  32'd1);
        tick();
        check({tag, ".done.pready"},   32'(REQ_PREADY),  32'(rdy));
        check({tag, ".done.prdata"},   REQ_PRDATA,       rdata);
        check({tag, ".done.pslverr"},  32'(REQ_PSLVERR), 32'(err));
        check({tag, ".done.psel"},     32'(PSEL_M),      32'd0);
        check({tag, ".done.penable"},  32'(PENABLE_M),   32'd0);
        check({tag, ".done.paddr"},    PADDR_M,          32'd0);
        tick();
        check({tag, ".resp.pready"},   32'(REQ_PREADY),  32'd0);
        check({tag, ".resp.pslverr"},  32'(REQ_PSLVERR), 32'd0);
        check({tag, ".resp.busy"},     32'(BUSY),        32'd0);
        check({tag, ".resp.prdata"},   REQ_PRDATA,       rdata);
    endtask

    initial begin
        PRESETN   = 1'b0;
        PRDATA_M  = 32'd0;
        PREADY_M  = 1'b0;
        PSLVERR_M = 1'b0;
        apply_reset();

        // Reset state
        check("rst.psel",    32'(PSEL_M),      32'd0);
        check("rst.penable", 32'(PENABLE_M),   32'd0);
        check("rst.paddr",   PADDR_M,          32'd0);
        check("rst.prdata",  REQ_PRDATA,       32'd0);
        check("rst.pready",  32'(REQ_PREADY),  32'd0);
        check("rst.pslverr", 32'(REQ_PSLVERR), 32'd0);
        check("rst.gnt_id",  32'(GNT_ID),      32'd0);
        check("rst.busy",    32'(BUSY),        32'd0);

        // T1: single write, slave always ready; write returns PRDATA 0
        PREADY_M = 1'b1;
        PRDATA_M = 32'hA5A5_A5A5;
        set_req(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        xfer("t1", 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'd0, 1'b0);
        drop_req(1'b0);

        // T2: simultaneous requests from reset alternate 0,1,0,1,0
        apply_reset();
        set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h1);
        set_req(1'b1, 1'b1, 1'b1, 32'h24, 32'h2);
        xfer("t2a", 1'b0, 32'h20, 32'h1, 1'b1, 32'd0, 1'b0);
        set_req(1'b0, 1'b1, 1'b1, 32'h28, 32'h3);
        xfer("t2b", 1'b1, 32'h24, 32'h2, 1'b1, 32'd0, 1'b0);
        set_req(1'b1, 1'b1, 1'b1, 32'h2C, 32'h4);
        xfer("t2c", 1'b0, 32'h28, 32'h3, 1'b1, 32'd0, 1'b0);
        set_req(1'b0, 1'b1, 1'b1, 32'h30, 32'h5);
        xfer("t2d", 1'b1, 32'h2C, 32'h4, 1'b1, 32'd0, 1'b0);
        drop_req(1'b1);
        xfer("t2e", 1'b0, 32'h30, 32'h5, 1'b1, 32'd0, 1'b0);
        drop_req(1'b0);

        // T3: req1 read with three wait states
        PREADY_M = 1'b0;
        PRDATA_M = 32'h1234_5678;
        set_req(1'b1, 1'b1, 1'b0, 32'h0100_0004, 32'd0);
        tick();
        check("t3.grant.gnt_id", 32'(GNT_ID),    32'd1);
        check("t3.grant.paddr",  PADDR_M,        32'h0100_0004);
        check("t3.grant.pwrite", 32'(PWRITE_M),  32'd0);
        check("t3.grant.penable", 32'(PENABLE_M), 32'd0);
        tick();
        check("t3.setup.penable", 32'(PENABLE_M), 32'd1);
        for (int w = 0; w < 3; w++) begin
            tick();
            check("t3.wait.penable", 32'(PENABLE_M),  32'd1);
            check("t3.wait.pready",  32'(REQ_PREADY), 32'd0);
        end
        PREADY_M = 1'b1;
        tick();
        check("t3.done.pready",  32'(REQ_PREADY),  32'b10);
        check("t3.done.prdata",  REQ_PRDATA,       32'h1234_5678);
        check("t3.done.pslverr", 32'(REQ_PSLVERR), 32'd0);
        check("t3.done.penable", 32'(PENABLE_M),   32'd0);
        tick();
        check("t3.resp.pready",  32'(REQ_PREADY),  32'd0);
        check("t3.resp.prdata",  REQ_PRDATA,       32'h1234_5678);
        drop_req(1'b1);

        // T4: hung slave aborted after exactly 8 ACCESS cycles
        PREADY_M = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'd0);
        tick();
        check("t4.grant.gnt_id", 32'(GNT_ID), 32'd0);
        tick();
        check("t4.setup.penable", 32'(PENABLE_M), 32'd1);
        for (int w = 0; w < TIMEOUT - 1; w++) begin
            tick();
            check("t4.wait.pready", 32'(REQ_PREADY), 32'd0);
            check("t4.wait.psel",   32'(PSEL_M),     32'd1);
        end
        tick();
        check("t4.abort.pready",  32'(REQ_PREADY),  32'b01);
        check("t4.abort.pslverr", 32'(REQ_PSLVERR), 32'd1);
        check("t4.abort.prdata",  REQ_PRDATA,       32'd0);
        check("t4.abort.psel",    32'(PSEL_M),      32'd0);
        check("t4.abort.penable", 32'(PENABLE_M),   32'd0);
        tick();
        check("t4.resp.pready",  32'(REQ_PREADY),  32'd0);
        check("t4.resp.pslverr", 32'(REQ_PSLVERR), 32'd0);
        PREADY_M = 1'b1;
        PRDATA_M = 32'h5555_AAAA;
        set_req(1'b0, 1'b1, 1'b1, 32'h34, 32'h77);
        xfer("t4n", 1'b0, 32'h34, 32'h77, 1'b1, 32'd0, 1'b0);
        drop_req(1'b0);

        // T5: slave error reported for the completion pulse only
        PSLVERR_M = 1'b1;
        PRDATA_M  = 32'hCAFE_0001;
        set_req(1'b1, 1'b1, 1'b0, 32'h40, 32'd0);
        xfer("t5", 1'b1, 32'h40, 32'd0, 1'b0, 32'hCAFE_0001, 1'b1);
        drop_req(1'b1);
        PSLVERR_M = 1'b0;
        PRDATA_M  = 32'h0BAD_F00D;
        set_req(1'b0, 1'b1, 1'b0, 32'h44, 32'd0);
        xfer("t5b", 1'b0, 32'h44, 32'd0, 1'b0, 32'h0BAD_F00D, 1'b0);
        drop_req(1'b0);

        // T6: reset in ACCESS clears outputs at once; req0 wins afterwards
        PREADY_M = 1'b0;
        set_req(1'b0, 1'b1, 1'b1, 32'h50, 32'h11);
        set_req(1'b1, 1'b1, 1'b1, 32'h54, 32'h22);
        tick();
        check("t6.grant.gnt_id", 32'(GNT_ID), 32'd1);
        tick();
        tick();
        check("t6.access.penable", 32'(PENABLE_M), 32'd1);
        #1;
        PRESETN = 1'b0;
        #1;
        check("t6.rst.psel",    32'(PSEL_M),      32'd0);
        check("t6.rst.penable", 32'(PENABLE_M),   32'd0);
        check("t6.rst.pwrite",  32'(PWRITE_M),    32'd0);
        check("t6.rst.paddr",   PADDR_M,          32'd0);
        check("t6.rst.pwdata",  PWDATA_M,         32'd0);
        check("t6.rst.prdata",  REQ_PRDATA,       32'd0);
        check("t6.rst.pready",  32'(REQ_PREADY),  32'd0);
        check("t6.rst.gnt_id",  32'(GNT_ID),      32'd0);
        check("t6.rst.busy",    32'(BUSY),        32'd0);
        tick();
        check("t6.rst_held.busy", 32'(BUSY), 32'd0);
        PRESETN  = 1'b1;
        PREADY_M = 1'b1;
        PRDATA_M = 32'h0;
        xfer("t6r", 1'b0, 32'h50, 32'h11, 1'b1, 32'd0, 1'b0);
        drop_req(1'b0);
        xfer("t6s", 1'b1, 32'h54, 32'h22, 1'b1, 32'd0, 1'b0);
        drop_req(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
